// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame/rate constants.
// Imported by the receive front end, the baud tick generator and the future TX serialiser.
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE = 16;  // sample ticks per bit
    localparam int unsigned UART_DATA_BITS  = 8;   // data bits per frame
    localparam int unsigned UART_DIV_WIDTH  = 16;  // width of the rate_div control

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick generator: one-cycle registered tick every rate_div clocks (rate_div = 0 acts as 1).
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   en, hold      - counter held at reload (no ticks) while en = 0 or hold = 1
//   rate_div      - clocks per tick
//   tick          - one-cycle pulse per rate_div clocks
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = UART_DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 hold,
    input  logic [DIV_WIDTH-1:0] rate_div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] reload_c;

    // rate_div is read at every reload, so a change lands on the next period.
    always_comb begin
        reload_c = '0;
        if (rate_div != '0) begin
            reload_c = rate_div - DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (!en || hold) begin
            cnt  <= reload_c;
            tick <= 1'b0;
        end else if (cnt == '0) begin
            cnt  <= reload_c;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt - DIV_WIDTH'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive front end: synchronises rx, oversamples it and deframes 8N1 characters
// into a one-entry valid/ready holding register, with framing/overrun error pulses.
// Ports:
//   clk, nReset         - clock, synchronous active-high reset
//   en, rate_div        - receiver enable, clocks per sample tick
//   rx                  - asynchronous serial line (idle high)
//   data, valid, ready  - holding register and consumer handshake
//   busy                - receiver is inside a frame
//   framing_err         - one-cycle pulse: stop bit sampled low
//   overrun_err         - one-cycle pulse: good byte dropped, holding register full
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int unsigned DATA_BITS   = UART_DATA_BITS,
    parameter int unsigned DIV_WIDTH   = UART_DIV_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] rate_div,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 busy,
    output logic                 framing_err,
    output logic                 overrun_err
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);

    rx_state_t              state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   tick;
    logic [CNT_W-1:0]       sample_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   bit_end_c;
    logic                   good_byte_c;

    // rx synchroniser, preset to the idle level.
    always_ff @(posedge clk) begin
        if (nReset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    // Tick counter is held in IDLE so the first tick is phase-aligned to start detection.
    uart_baud_tick #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_tick (
        .clk      (clk),
        .rst      (nReset),
        .en       (en),
        .hold     (state == IDLE),
        .rate_div (rate_div),
        .tick     (tick)
    );

    assign bit_end_c   = tick && (sample_cnt == CNT_W'(OVERSAMPLE - 1));
    assign good_byte_c = en && (state == STOP) && bit_end_c && rxs;

    // Deframing FSM; busy is registered alongside every state change.
    always_ff @(posedge clk) begin
        if (nReset) begin
            state       <= IDLE;
            sample_cnt  <= '0;
            bit_cnt     <= '0;
            shift_q     <= '0;
            busy        <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            framing_err <= 1'b0;
            if (!en) begin
                state      <= IDLE;
                busy       <= 1'b0;
                sample_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        sample_cnt <= '0;
                        if (!rxs) begin
                            state <= START;
                            busy  <= 1'b1;
                        end
                    end
                    START: begin
                        if (tick) begin
                            if (sample_cnt == CNT_W'(OVERSAMPLE / 2 - 1)) begin
                                sample_cnt <= '0;
                                bit_cnt    <= '0;
                                if (rxs) begin
                                    state <= IDLE;  // glitch shorter than half a bit
                                    busy  <= 1'b0;
                                end else begin
                                    state <= DATA;
                                end
                            end else begin
                                sample_cnt <= sample_cnt + CNT_W'(1);
                            end
                        end
                    end
                    DATA: begin
                        if (bit_end_c) begin
                            sample_cnt <= '0;
                            shift_q    <= {rxs, shift_q[DATA_BITS-1:1]};
                            bit_cnt    <= bit_cnt + BIT_W'(1);
                            if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                                state <= STOP;
                            end
                        end else if (tick) begin
                            sample_cnt <= sample_cnt + CNT_W'(1);
                        end
                    end
                    STOP: begin
                        if (bit_end_c) begin
                            sample_cnt <= '0;
                            if (rxs) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state       <= BREAK;
                                framing_err <= 1'b1;
                            end
                        end else if (tick) begin
                            sample_cnt <= sample_cnt + CNT_W'(1);
                        end
                    end
                    BREAK: begin
                        // Line held low reports once; wait for it to return high.
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // One-entry holding register; a byte arriving while full is dropped and flagged.
    always_ff @(posedge clk) begin
        if (nReset) begin
            data        <= '0;
            valid       <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (good_byte_c) begin
                if (!valid || ready) begin
                    data  <= shift_q;
                    valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule
